muldiv_iterative_unit: RTL and testbench

- Parametrised iterative M-extension execute unit; replaces the fixed 32-bit iterative multiplier and combinational divider.
- Executes all eight RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in one shared shift datapath, UNROLL bits per cycle.
- Sits beside the ALU in Execute; hazard unit stalls F/D/E on busy; writeback is muxed from result on done.

---
 rtl/muldiv_iterative_unit_if.sv | 16 +
 rtl/muldiv_iterative_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_iterative_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iterative_unit_if.sv
// Request/response bundle between the Execute stage and the iterative M-extension unit.
interface muldiv_iterative_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] operand1;
   logic [XLEN-1:0] operand2;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, op, operand1, operand2, kill, input busy, done, result);
   modport slave  (input start, op, operand1, operand2, kill, output busy, done, result);
endinterface

// File: rtl/muldiv_iterative_unit.sv
// Iterative RV32M execute unit: shared shift datapath for shift-add multiply and
// restoring divide, UNROLL bits per cycle, sign fix-up applied when the result is captured.
module muldiv_iterative_unit #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   muldiv_iterative_unit_if.slave bus
);
   localparam int N  = XLEN / UNROLL;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]     CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
   localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t            state_r, state_nxt_s;
   logic [2:0]        op_r;
   logic              s1_r, s2_r;
   logic [CW-1:0]     cnt_r;
   logic [XLEN-1:0]   mag2_r;
   logic [2*XLEN-1:0] prod_r, prod_nxt_s;
   logic [XLEN:0]     rem_r, rem_nxt_s, sum_s;
   logic              busy_r, done_r;
   logic [XLEN-1:0]   result_r;
   logic              accept_s, fast_s, sign1_s, sign2_s;
   logic [XLEN-1:0]   fast_val_s, mag1_s, mag2_s;

   // Sign-corrected architectural result from the raw product / quotient / remainder.
   function automatic logic [XLEN-1:0] final_value(input logic [2:0] op, input logic s1,
                                                   input logic s2, input logic [2*XLEN-1:0] prod,
                                                   input logic [XLEN:0] rem);
      logic [2*XLEN-1:0] full;
      full = (s1 ^ s2) ? ({(2*XLEN){1'b0}} - prod) : prod;
      case (op)
         3'b000:                 final_value = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_value = full[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_value = (s1 ^ s2) ? (ZERO - prod[XLEN-1:0]) : prod[XLEN-1:0];
         default:                final_value = s1 ? (ZERO - rem[XLEN-1:0]) : rem[XLEN-1:0];
      endcase
   endfunction

   // Request decode: operand magnitudes, sign flags and the divide fast paths.
   always_comb begin
      sign1_s    = bus.operand1[XLEN-1] & ((bus.op == 3'b001) | (bus.op == 3'b010) |
                                           (bus.op == 3'b100) | (bus.op == 3'b110));
      sign2_s    = bus.operand2[XLEN-1] & ((bus.op == 3'b001) | (bus.op == 3'b100) |
                                           (bus.op == 3'b110));
      mag1_s     = sign1_s ? (ZERO - bus.operand1) : bus.operand1;
      mag2_s     = sign2_s ? (ZERO - bus.operand2) : bus.operand2;
      fast_s     = 1'b0;
      fast_val_s = ZERO;
      if (bus.op[2] && (bus.operand2 == ZERO)) begin
         fast_s     = 1'b1;
         fast_val_s = bus.op[1] ? bus.operand1 : ALL_ONES;
      end else if (bus.op[2] && !bus.op[0] && (bus.operand1 == INT_MIN) &&
                   (bus.operand2 == ALL_ONES)) begin
         fast_s     = 1'b1;
         fast_val_s = bus.op[1] ? ZERO : bus.operand1;
      end else begin
         fast_s     = 1'b0;
      end
   end

   // One iteration step: UNROLL shift-add or restoring-subtract bits.
   always_comb begin
      prod_nxt_s = prod_r;
      rem_nxt_s  = rem_r;
      sum_s      = {(XLEN+1){1'b0}};
      for (int i = 0; i < UNROLL; i++) begin
         if (op_r[2]) begin
            rem_nxt_s              = {rem_nxt_s[XLEN-1:0], prod_nxt_s[XLEN-1]};
            prod_nxt_s[XLEN-1:0]   = {prod_nxt_s[XLEN-2:0], 1'b0};
            if (rem_nxt_s >= {1'b0, mag2_r}) begin
               rem_nxt_s     = rem_nxt_s - {1'b0, mag2_r};
               prod_nxt_s[0] = 1'b1;
            end else begin
               prod_nxt_s[0] = 1'b0;
            end
         end else begin
            sum_s      = {1'b0, prod_nxt_s[2*XLEN-1:XLEN]} +
                         (prod_nxt_s[0] ? {1'b0, mag2_r} : {(XLEN+1){1'b0}});
            prod_nxt_s = {sum_s, prod_nxt_s[XLEN-1:1]};
         end
      end
   end

   // Next-state logic; kill overrides start, start is only honoured in IDLE/DONE.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (bus.kill) begin
               state_nxt_s = IDLE;
            end else if (bus.start) begin
               accept_s    = 1'b1;
               state_nxt_s = fast_s ? DONE : CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (bus.kill) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = CALC;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath registers: load latched operands on accept, iterate while in CALC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_r   <= 3'b000;
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         cnt_r  <= {CW{1'b0}};
         mag2_r <= ZERO;
         prod_r <= {(2*XLEN){1'b0}};
         rem_r  <= {(XLEN+1){1'b0}};
      end else if (accept_s) begin
         op_r   <= bus.op;
         s1_r   <= sign1_s;
         s2_r   <= sign2_s;
         cnt_r  <= {CW{1'b0}};
         mag2_r <= mag2_s;
         prod_r <= {ZERO, mag1_s};
         rem_r  <= {(XLEN+1){1'b0}};
      end else if (state_r == CALC) begin
         prod_r <= prod_nxt_s;
         rem_r  <= rem_nxt_s;
         cnt_r  <= cnt_r + CNT_ONE;
      end else begin
         prod_r <= prod_r;
      end
   end

   // Output registers; result changes only when a new value is captured.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= ZERO;
      end else begin
         busy_r <= (state_nxt_s == CALC);
         done_r <= (state_nxt_s == DONE);
         if (accept_s && fast_s) begin
            result_r <= fast_val_s;
         end else if ((state_r == CALC) && (state_nxt_s == DONE)) begin
            result_r <= final_value(op_r, s1_r, s2_r, prod_nxt_s, rem_nxt_s);
         end else begin
            result_r <= result_r;
         end
      end
   end

   // A flush arriving in the DONE cycle suppresses the pulse.
   assign bus.busy   = busy_r;
   assign bus.done   = done_r & ~bus.kill;
   assign bus.result = result_r;
endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// Bench for muldiv_iterative_unit: three configurations driven in parallel, checked every
// cycle against an arithmetic reference model, plus directed literal expectations.
module tb_muldiv_iterative_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   int          cyc = 0;
   int          t_acc = 0;
   int          checks = 0;
   int          failures = 0;

   int          m_left [3] = '{0, 0, 0};
   logic        m_done [3] = '{1'b0, 1'b0, 1'b0};
   logic [31:0] m_res  [3] = '{32'd0, 32'd0, 32'd0};
   logic [31:0] m_pend [3] = '{32'd0, 32'd0, 32'd0};
   logic        d_busy [3];
   logic        d_done [3];
   logic [31:0] d_res  [3];

   muldiv_iterative_unit_if #(.XLEN(32)) bus0 ();
   muldiv_iterative_unit_if #(.XLEN(16)) bus1 ();
   muldiv_iterative_unit_if #(.XLEN(16)) bus2 ();

   muldiv_iterative_unit #(.XLEN(32), .UNROLL(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   muldiv_iterative_unit #(.XLEN(16), .UNROLL(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   muldiv_iterative_unit #(.XLEN(16), .UNROLL(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   assign bus0.start = start;  assign bus1.start = start;  assign bus2.start = start;
   assign bus0.kill  = kill;   assign bus1.kill  = kill;   assign bus2.kill  = kill;
   assign bus0.op    = op;     assign bus1.op    = op;     assign bus2.op    = op;
   assign bus0.operand1 = a;   assign bus1.operand1 = a[15:0]; assign bus2.operand1 = a[15:0];
   assign bus0.operand2 = b;   assign bus1.operand2 = b[15:0]; assign bus2.operand2 = b[15:0];

   always_comb begin
      d_busy[0] = bus0.busy; d_done[0] = bus0.done; d_res[0] = bus0.result;
      d_busy[1] = bus1.busy; d_done[1] = bus1.done; d_res[1] = {16'd0, bus1.result};
      d_busy[2] = bus2.busy; d_done[2] = bus2.done; d_res[2] = {16'd0, bus2.result};
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int xl_of(input int k);
      return (k == 0) ? 32 : 16;
   endfunction

   function automatic int n_of(input int k);
      return (k == 0) ? 32 : ((k == 1) ? 4 : 8);
   endfunction

   // Architectural RV32M result for an xl-bit machine, from plain integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x,
                                              input logic [31:0] y, input int xl);
      logic [63:0] mask, ux, uy, r;
      longint      sx, sy, lo_min;
      mask   = (64'd1 << xl) - 64'd1;
      ux     = {32'd0, x} & mask;
      uy     = {32'd0, y} & mask;
      sx     = x[xl-1] ? longint'(ux) - longint'(64'd1 << xl) : longint'(ux);
      sy     = y[xl-1] ? longint'(uy) - longint'(64'd1 << xl) : longint'(uy);
      lo_min = -(longint'(1) << (xl - 1));
      case (f)
         3'd0: r = ux * uy;
         3'd1: r = 64'(((sx * sy) >>> xl));
         3'd2: r = 64'(((sx * longint'(uy)) >>> xl));
         3'd3: r = (ux * uy) >> xl;
         3'd4: r = (uy == 64'd0) ? mask : ((sx == lo_min && sy == -1) ? ux : 64'(sx / sy));
         3'd5: r = (uy == 64'd0) ? mask : ux / uy;
         3'd6: r = (uy == 64'd0) ? ux : ((sx == lo_min && sy == -1) ? 64'd0 : 64'(sx % sy));
         default: r = (uy == 64'd0) ? ux : ux % uy;
      endcase
      r = r & mask;
      return r[31:0];
   endfunction

   function automatic logic is_fast(input logic [2:0] f, input logic [31:0] x,
                                    input logic [31:0] y, input int xl);
      logic [63:0] mask, ux, uy;
      mask = (64'd1 << xl) - 64'd1;
      ux   = {32'd0, x} & mask;
      uy   = {32'd0, y} & mask;
      return f[2] && ((uy == 64'd0) ||
             (!f[0] && ux == (64'd1 << (xl - 1)) && uy == mask));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: an accepted op completes N cycles later, fast paths next cycle.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            m_left[k] <= 0; m_done[k] <= 1'b0; m_res[k] <= 32'd0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (kill) begin
               m_left[k] <= 0; m_done[k] <= 1'b0;
            end else if (m_left[k] == 0 && start) begin
               if (is_fast(op, a, b, xl_of(k))) begin
                  m_done[k] <= 1'b1; m_res[k] <= ref_result(op, a, b, xl_of(k));
               end else begin
                  m_left[k] <= n_of(k); m_done[k] <= 1'b0;
                  m_pend[k] <= ref_result(op, a, b, xl_of(k));
               end
            end else if (m_left[k] != 0) begin
               m_left[k] <= m_left[k] - 1;
               m_done[k] <= (m_left[k] == 1);
               if (m_left[k] == 1) m_res[k] <= m_pend[k];
            end else begin
               m_done[k] <= 1'b0;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of all three units against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         check($sformatf("busy%0d", k), {31'd0, d_busy[k]}, {31'd0, m_left[k] != 0});
         check($sformatf("done%0d", k), {31'd0, d_done[k]}, {31'd0, m_done[k] && !kill});
         check($sformatf("result%0d", k), d_res[k], m_res[k]);
      end
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      @(posedge clk); #1;
      op = f; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      t_acc = cyc; start = 1'b0;
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_done(input int k, input int budget, output int lat);
      lat = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (d_done[k]) begin
            lat = cyc - t_acc + 1;
            break;
         end
      end
   endtask

   task automatic run(input string name, input logic [2:0] f, input logic [31:0] x,
                      input logic [31:0] y, input int k, input logic [31:0] exp, input int exp_lat);
      int lat;
      issue(f, x, y);
      wait_done(k, 200, lat);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_value"}, d_res[k], exp);
   endtask

   initial begin
      int lat, n;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, d_busy[0]}, 32'd0);
      check("reset_done", {31'd0, d_done[0]}, 32'd0);
      check("reset_result", d_res[0], 32'd0);
      #2 rst = 1'b1;

      check("model_mul", ref_result(3'd0, 32'd7, 32'hFFFFFFFD, 32), 32'hFFFFFFEB);
      check("model_mulhsu", ref_result(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32), 32'hFFFFFFFF);
      check("model_div", ref_result(3'd4, 32'hFFFFFFF9, 32'd2, 32), 32'hFFFFFFFD);
      check("model_rem", ref_result(3'd6, 32'hFFFFFFF9, 32'd2, 32), 32'hFFFFFFFF);

      run("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 0, 32'hFFFFFFEB, 33);
      run("mulh",   3'd1, 32'h80000000, 32'h80000000, 0, 32'h40000000, 33);
      run("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 33);
      run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 33);

      // kill at iteration 10, with an ignored start in CALC beforehand
      issue(3'd0, 32'd5, 32'd6);
      repeat (3) @(posedge clk);
      #1 op = 3'd5; a = 32'd9; b = 32'd2; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1 kill = 1'b0;
      @(negedge clk);
      check("kill_busy", {31'd0, d_busy[0]}, 32'd0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (d_done[0]) n++;
      end
      check("kill_no_done", 32'(n), 32'd0);
      check("kill_result_kept", d_res[0], 32'hFFFFFFFF);

      @(posedge clk); #1 op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; kill = 1'b1;
      @(posedge clk); #1 start = 1'b0; kill = 1'b0;
      @(negedge clk);
      check("startkill_busy", {31'd0, d_busy[0]}, 32'd0);
      check("startkill_done", {31'd0, d_done[0]}, 32'd0);

      run("div",  3'd4, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 33);
      run("rem",  3'd6, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 33);

      run("divu_b2b", 3'd5, 32'd100, 32'd7, 0, 32'd14, 33);
      op = 3'd7; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(0, 200, lat);
      check("remu_b2b_latency", 32'(lat), 32'd66);
      check("remu_b2b_value", d_res[0], 32'd2);

      run("divu_zero", 3'd5, 32'd5, 32'd0, 0, 32'hFFFFFFFF, 1);
      run("rem_zero",  3'd6, 32'd5, 32'd0, 0, 32'd5, 1);
      run("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 1);
      run("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0, 1);

      repeat (12) @(posedge clk);
      run("x16u4_mul", 3'd0, 32'h000000FF, 32'h00000101, 1, 32'h0000FFFF, 5);
      wait_done(0, 200, lat);
      repeat (4) @(posedge clk);
      run("x16u2_divu", 3'd5, 32'h0000FFFF, 32'd3, 2, 32'h00005555, 9);
      wait_done(0, 200, lat);

      issue(3'd0, 32'd11, 32'd13);
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_rst_busy", {31'd0, d_busy[0]}, 32'd0);
      check("async_rst_done", {31'd0, d_done[0]}, 32'd0);
      check("async_rst_result", d_res[0], 32'd0);
      @(posedge clk); #2 rst = 1'b1;
      run("mul_after_rst", 3'd0, 32'd3, 32'd4, 0, 32'd12, 33);

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
